// File: rtl/pattern_check_pkg.sv
// Shared widths, sequencer state codes, expected-record layout and checker FSM states.
// Optional state compare is selected with PATTERN_CHECKER_STATE_EN.
package pattern_check_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned PAT_W = 4;
  localparam int unsigned CC_W  = 12;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd1;
  localparam logic [ST_W-1:0] ST_FLUSH   = 2'd2;
  localparam logic [ST_W-1:0] ST_PRETRIG = 2'd3;

  typedef struct packed {
    logic [KEY_W-1:0] key_1st;
    logic [PAT_W-1:0] pat_1st;
    logic [CC_W-1:0]  ccode_1st;
    logic [KEY_W-1:0] key_2nd;
    logic [PAT_W-1:0] pat_2nd;
    logic [CC_W-1:0]  ccode_2nd;
`ifdef PATTERN_CHECKER_STATE_EN
    logic [ST_W-1:0]  state;
`endif
  } exp_rec_t;

  typedef enum logic [1:0] {
    CK_IDLE,
    CK_RUN,
    CK_DRAIN,
    CK_DONE
  } chk_state_e;

endpackage

// File: rtl/exp_delay_line.sv
// Fixed-depth shift register carrying a data word and its valid bit; busy_o flags any
// occupied slot so the checker knows when the pipeline has drained.
module exp_delay_line #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output logic         busy_o
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     data_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];
  assign busy_o = |vld_q;

endmodule

// File: rtl/pattern_checker.sv
// Scoreboard aligning expected CLCT records with pattern-finder results and counting failing vectors.
// Define PATTERN_CHECKER_STATE_EN to include the sequencer-state compare.
module pattern_checker
  import pattern_check_pkg::*;
#(
  parameter int unsigned MXADRB  = 10,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned MXERRB  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              increment,
  input  logic [MXADRB-1:0] adr_in,
  input  logic              reader_done,
  input  logic [KEY_W-1:0]  key_exp_1st,
  input  logic [KEY_W-1:0]  key_exp_2nd,
  input  logic [PAT_W-1:0]  pat_exp_1st,
  input  logic [PAT_W-1:0]  pat_exp_2nd,
  input  logic [CC_W-1:0]   ccode_exp_1st,
  input  logic [CC_W-1:0]   ccode_exp_2nd,
  input  logic [ST_W-1:0]   state_exp,
  input  logic [KEY_W-1:0]  key_dut_1st,
  input  logic [KEY_W-1:0]  key_dut_2nd,
  input  logic [PAT_W-1:0]  pat_dut_1st,
  input  logic [PAT_W-1:0]  pat_dut_2nd,
  input  logic [CC_W-1:0]   ccode_dut_1st,
  input  logic [CC_W-1:0]   ccode_dut_2nd,
  input  logic [ST_W-1:0]   state_dut,
  output logic              err_1st,
  output logic              err_2nd,
  output logic              err_state,
  output logic [MXERRB-1:0] err_cnt,
  output logic [MXADRB:0]   chk_cnt,
  output logic [MXADRB-1:0] first_err_adr,
  output logic              first_err_vld,
  output logic              done,
  output logic              pass
);

  localparam int unsigned DL_W = MXADRB + $bits(exp_rec_t);

  chk_state_e        state_q, state_d;
  exp_rec_t          rec_in, rec_chk;
  logic [MXADRB-1:0] adr_chk;
  logic              vld_chk, busy, accept;
  logic              mis_1st, mis_2nd, mis_st, mis_any;

  logic              err_1st_q, err_1st_d, err_2nd_q, err_2nd_d, err_st_q, err_st_d;
  logic [MXERRB-1:0] err_cnt_q, err_cnt_d;
  logic [MXADRB:0]   chk_cnt_q, chk_cnt_d;
  logic [MXADRB-1:0] first_adr_q, first_adr_d;
  logic              first_vld_q, first_vld_d;

  // Only IDLE and RUN admit vectors; the IDLE->RUN strobe itself is enqueued.
  assign accept = increment && (state_q == CK_IDLE || state_q == CK_RUN);

  always_comb begin
    rec_in           = '0;
    rec_in.key_1st   = key_exp_1st;
    rec_in.pat_1st   = pat_exp_1st;
    rec_in.ccode_1st = ccode_exp_1st;
    rec_in.key_2nd   = key_exp_2nd;
    rec_in.pat_2nd   = pat_exp_2nd;
    rec_in.ccode_2nd = ccode_exp_2nd;
`ifdef PATTERN_CHECKER_STATE_EN
    rec_in.state     = state_exp;
`endif
  end

  exp_delay_line #(.DEPTH(LATENCY), .W(DL_W)) u_dly (
    .clk_i  (clock),
    .rst_i  (reset),
    .vld_i  (accept),
    .data_i ({adr_in, rec_in}),
    .vld_o  (vld_chk),
    .data_o ({adr_chk, rec_chk}),
    .busy_o (busy)
  );

  assign mis_1st = vld_chk && ({key_dut_1st, pat_dut_1st, ccode_dut_1st} !=
                               {rec_chk.key_1st, rec_chk.pat_1st, rec_chk.ccode_1st});
  assign mis_2nd = vld_chk && ({key_dut_2nd, pat_dut_2nd, ccode_dut_2nd} !=
                               {rec_chk.key_2nd, rec_chk.pat_2nd, rec_chk.ccode_2nd});
`ifdef PATTERN_CHECKER_STATE_EN
  assign mis_st  = vld_chk && (state_dut != rec_chk.state);
`else
  logic unused_state;
  assign mis_st       = 1'b0;
  assign unused_state = ^{state_exp, state_dut};
`endif
  assign mis_any = mis_1st | mis_2nd | mis_st;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CK_IDLE:  if (increment)   state_d = CK_RUN;
      CK_RUN:   if (reader_done) state_d = CK_DRAIN;
      CK_DRAIN: if (!busy)       state_d = CK_DONE;
      CK_DONE:                   state_d = CK_DONE;
      default:                   state_d = CK_IDLE;
    endcase
  end

  always_comb begin
    err_1st_d   = mis_1st;
    err_2nd_d   = mis_2nd;
    err_st_d    = mis_st;
    err_cnt_d   = err_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    first_adr_d = first_adr_q;
    first_vld_d = first_vld_q;
    if (vld_chk) chk_cnt_d = chk_cnt_q + 1'b1;
    if (mis_any && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    if (mis_any && !first_vld_q) begin
      first_adr_d = adr_chk;
      first_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CK_IDLE;
      err_1st_q   <= 1'b0;
      err_2nd_q   <= 1'b0;
      err_st_q    <= 1'b0;
      err_cnt_q   <= '0;
      chk_cnt_q   <= '0;
      first_adr_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_1st_q   <= err_1st_d;
      err_2nd_q   <= err_2nd_d;
      err_st_q    <= err_st_d;
      err_cnt_q   <= err_cnt_d;
      chk_cnt_q   <= chk_cnt_d;
      first_adr_q <= first_adr_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign err_1st       = err_1st_q;
  assign err_2nd       = err_2nd_q;
  assign err_state     = err_st_q;
  assign err_cnt       = err_cnt_q;
  assign chk_cnt       = chk_cnt_q;
  assign first_err_adr = first_adr_q;
  assign first_err_vld = first_vld_q;
  assign done          = (state_q == CK_DONE);
  assign pass          = done && (err_cnt_q == '0);

endmodule

// File: tb/tb_pattern_checker.sv
// Randomized scoreboard bench for pattern_checker: a default instance plus a 4-bit error-counter
// instance share one stimulus stream; expectations come from per-vector corruption masks.
module tb_pattern_checker;
  localparam int unsigned MXADRB  = 10;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned MXERRB  = 16;
`ifdef PATTERN_CHECKER_STATE_EN
  localparam bit STATE_EN = 1'b1;
`else
  localparam bit STATE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  k1; logic [3:0] p1; logic [11:0] c1;
    logic [7:0]  k2; logic [3:0] p2; logic [11:0] c2;
    logic [1:0]  st;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, increment, reader_done;
  logic [MXADRB-1:0] adr_in;
  logic [7:0]  key_exp_1st, key_exp_2nd, key_dut_1st, key_dut_2nd;
  logic [3:0]  pat_exp_1st, pat_exp_2nd, pat_dut_1st, pat_dut_2nd;
  logic [11:0] ccode_exp_1st, ccode_exp_2nd, ccode_dut_1st, ccode_dut_2nd;
  logic [1:0]  state_exp, state_dut;

  logic              err_1st, err_2nd, err_state, first_err_vld, done, pass;
  logic [MXERRB-1:0] err_cnt;
  logic [MXADRB:0]   chk_cnt;
  logic [MXADRB-1:0] first_err_adr;

  logic              s_err_1st, s_err_2nd, s_err_state, s_first_err_vld, s_done, s_pass;
  logic [3:0]        s_err_cnt;
  logic [MXADRB:0]   s_chk_cnt;
  logic [MXADRB-1:0] s_first_err_adr;

  pattern_checker #(.MXADRB(MXADRB), .LATENCY(LATENCY), .MXERRB(MXERRB)) u_dut (
    .clock(clock), .reset(reset), .increment(increment), .adr_in(adr_in), .reader_done(reader_done),
    .key_exp_1st(key_exp_1st), .key_exp_2nd(key_exp_2nd), .pat_exp_1st(pat_exp_1st),
    .pat_exp_2nd(pat_exp_2nd), .ccode_exp_1st(ccode_exp_1st), .ccode_exp_2nd(ccode_exp_2nd),
    .state_exp(state_exp), .key_dut_1st(key_dut_1st), .key_dut_2nd(key_dut_2nd),
    .pat_dut_1st(pat_dut_1st), .pat_dut_2nd(pat_dut_2nd), .ccode_dut_1st(ccode_dut_1st),
    .ccode_dut_2nd(ccode_dut_2nd), .state_dut(state_dut),
    .err_1st(err_1st), .err_2nd(err_2nd), .err_state(err_state), .err_cnt(err_cnt),
    .chk_cnt(chk_cnt), .first_err_adr(first_err_adr), .first_err_vld(first_err_vld),
    .done(done), .pass(pass)
  );

  pattern_checker #(.MXADRB(MXADRB), .LATENCY(LATENCY), .MXERRB(4)) u_sat (
    .clock(clock), .reset(reset), .increment(increment), .adr_in(adr_in), .reader_done(reader_done),
    .key_exp_1st(key_exp_1st), .key_exp_2nd(key_exp_2nd), .pat_exp_1st(pat_exp_1st),
    .pat_exp_2nd(pat_exp_2nd), .ccode_exp_1st(ccode_exp_1st), .ccode_exp_2nd(ccode_exp_2nd),
    .state_exp(state_exp), .key_dut_1st(key_dut_1st), .key_dut_2nd(key_dut_2nd),
    .pat_dut_1st(pat_dut_1st), .pat_dut_2nd(pat_dut_2nd), .ccode_dut_1st(ccode_dut_1st),
    .ccode_dut_2nd(ccode_dut_2nd), .state_dut(state_dut),
    .err_1st(s_err_1st), .err_2nd(s_err_2nd), .err_state(s_err_state), .err_cnt(s_err_cnt),
    .chk_cnt(s_chk_cnt), .first_err_adr(s_first_err_adr), .first_err_vld(s_first_err_vld),
    .done(s_done), .pass(s_pass)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t ev [64];
  vec_t mk [64];

  task automatic gen(input int n);
    logic [63:0] r;
    for (int v = 0; v < 64; v++) begin
      r = {$urandom(), $urandom()};
      ev[v]    = r[57:0];
      ev[v].st = 2'($urandom_range(1, 3));
      mk[v]    = '0;
    end
    if (n > 64) $fatal(1, "FAIL gen: vector count %0d exceeds table", n);
  endtask

  task automatic drive_exp(input int v, input bit inc);
    increment = inc;
    adr_in    = MXADRB'(v);
    {key_exp_1st, pat_exp_1st, ccode_exp_1st, key_exp_2nd, pat_exp_2nd, ccode_exp_2nd, state_exp} = ev[v];
  endtask

  task automatic drive_dut(input int v, input bit real_v);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if (real_v)
      {key_dut_1st, pat_dut_1st, ccode_dut_1st, key_dut_2nd, pat_dut_2nd, ccode_dut_2nd, state_dut} = ev[v] ^ mk[v];
    else
      {key_dut_1st, pat_dut_1st, ccode_dut_1st, key_dut_2nd, pat_dut_2nd, ccode_dut_2nd, state_dut} = r[57:0];
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; increment = 1'b0; reader_done = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Streams n vectors from ev/mk with the pattern finder modelled as a LATENCY-clock delay.
  task automatic run_vectors(input int n, input bit with_reset, input string name);
    int p1 = 0, p2 = 0, ps = 0, e1 = 0, e2 = 0, es = 0, errs = 0, first = -1, done_c = -1;
    bit f1, f2, fs;
    for (int v = 0; v < n; v++) begin
      f1 = |{mk[v].k1, mk[v].p1, mk[v].c1};
      f2 = |{mk[v].k2, mk[v].p2, mk[v].c2};
      fs = STATE_EN && (mk[v].st != 2'd0);
      e1 += int'(f1); e2 += int'(f2); es += int'(fs);
      if (f1 || f2 || fs) begin
        errs++;
        if (first < 0) first = v;
      end
    end
    if (with_reset) do_reset();
    for (int c = 0; c < n + LATENCY + 40; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
        p1 += int'(err_1st); p2 += int'(err_2nd); ps += int'(err_state);
        if (done) begin done_c = c; break; end
      end
      drive_exp((c < n) ? c : 0, c < n);
      reader_done = (c >= n - 1);
      drive_dut(c - LATENCY, (c >= LATENCY) && (c - LATENCY < n));
    end
    increment = 1'b0;
    n_checks++;
    if (done_c < 0 || done_c - (n - 1) > LATENCY + 2) begin
      n_fail++; $display("FAIL %s done_latency: got %0d clks (-1 timeout) want <= %0d",
                         name, (done_c < 0) ? -1 : done_c - (n - 1), LATENCY + 2);
    end
    n_checks++;
    if (err_cnt !== MXERRB'((errs > 65535) ? 65535 : errs)) begin
      n_fail++; $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, errs);
    end
    n_checks++;
    if (s_err_cnt !== 4'((errs > 15) ? 15 : errs)) begin
      n_fail++; $display("FAIL %s sat_err_cnt: got %0d want %0d", name, s_err_cnt, (errs > 15) ? 15 : errs);
    end
    n_checks++;
    if (chk_cnt !== (MXADRB+1)'(n) || s_chk_cnt !== (MXADRB+1)'(n)) begin
      n_fail++; $display("FAIL %s chk_cnt: got %0d/%0d want %0d", name, chk_cnt, s_chk_cnt, n);
    end
    n_checks++;
    if (first_err_vld !== (errs > 0) || first_err_adr !== MXADRB'((errs > 0) ? first : 0)) begin
      n_fail++; $display("FAIL %s first_err: got vld=%0b adr=%0d want vld=%0b adr=%0d",
                         name, first_err_vld, first_err_adr, errs > 0, (errs > 0) ? first : 0);
    end
    n_checks++;
    if (done !== 1'b1 || pass !== (errs == 0)) begin
      n_fail++; $display("FAIL %s done_pass: got done=%0b pass=%0b want done=1 pass=%0b", name, done, pass, errs == 0);
    end
    n_checks++;
    if (p1 != e1 || p2 != e2 || ps != es) begin
      n_fail++; $display("FAIL %s err_pulses: got 1st=%0d 2nd=%0d st=%0d want %0d %0d %0d", name, p1, p2, ps, e1, e2, es);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      drive_exp(c, 1'b1);
      drive_dut(c, 1'b0);
    end
    increment = 1'b0;
    repeat (LATENCY + 2) @(posedge clock);
    #1;
    n_checks++;
    if (chk_cnt !== (MXADRB+1)'(n) || done !== 1'b1) begin
      n_fail++; $display("FAIL %s ignore_after_done: got chk_cnt=%0d done=%0b want %0d 1", name, chk_cnt, done, n);
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({err_1st, err_2nd, err_state, err_cnt, chk_cnt, first_err_adr, first_err_vld, done, pass} !== '0 ||
        {s_err_cnt, s_chk_cnt, s_first_err_vld, s_done, s_pass} !== '0) begin
      n_fail++; $display("FAIL %s outputs_zero: got err_cnt=%0d chk_cnt=%0d first=%0b/%0d done=%0b pass=%0b want all 0",
                         name, err_cnt, chk_cnt, first_err_vld, first_err_adr, done, pass);
    end
  endtask

  task automatic test_reset();
    gen(1);
    do_reset();
    check_zero("reset");
  endtask

  task automatic test_clean();
    gen(16);
    run_vectors(16, 1'b1, "clean");
  endtask

  task automatic test_single_key();
    gen(16);
    mk[5].k1 = 8'($urandom_range(1, 255));
    run_vectors(16, 1'b1, "single_key");
  endtask

  task automatic test_multi();
    gen(16);
    mk[3].k1 = 8'h01;
    mk[3].c2 = 12'h800;
    mk[9].p2 = 4'($urandom_range(1, 15));
    run_vectors(16, 1'b1, "multi");
  endtask

  task automatic test_saturation();
    gen(20);
    for (int v = 0; v < 20; v++) mk[v].c1 = 12'($urandom_range(1, 4095));
    run_vectors(20, 1'b1, "saturation");
  endtask

  task automatic test_reset_midrun();
    gen(16);
    for (int v = 0; v < 16; v++) mk[v].k2 = 8'hFF;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      drive_exp(c, 1'b1);
      drive_dut(c - LATENCY, c >= LATENCY);
    end
    @(posedge clock); #1;
    reset = 1'b1; increment = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check_zero("reset_midrun");
    gen(10);
    run_vectors(10, 1'b0, "rerun");
  endtask

  task automatic test_state();
    gen(8);
    ev[0].st = 2'd3;
    mk[0].st = 2'd1;
    run_vectors(8, 1'b1, "state");
  endtask

  task automatic test_random();
    gen(40);
    for (int v = 0; v < 40; v++) begin
      if ($urandom_range(0, 3) == 0) mk[v].p1 = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) mk[v].k2 = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 5) == 0) mk[v].st = 2'($urandom_range(1, 3));
    end
    run_vectors(40, 1'b1, "random");
  endtask

  initial begin
    reset = 1'b1; increment = 1'b0; reader_done = 1'b0; adr_in = '0;
    gen(1);
    drive_exp(0, 1'b0);
    drive_dut(0, 1'b0);
    test_reset();
    test_clean();
    test_single_key();
    test_multi();
    test_saturation();
    test_reset_midrun();
    test_state();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
